regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback end of the integer register file: accepts results from the execute/ALU stage over a valid/ready handshake, queues them in a 2-entry FIFO, and commits one per cycle into architected registers x1..x31 during the writeback stage. It also provides the two combinational read ports that the decode stage uses for rs1/rs2 and a pending-write scoreboard. Together with decode it forms the writer/reader pair of the register file; `itype` codes come from the shared `itype.v` definitions.

## Interface
Parameters:
- WB_STAGE, 3'd4, value of stage_i during which the FIFO head may commit
- FIFO_DEPTH, 2, result queue depth (fixed at 2; other values unsupported)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state when 0
- stage_i  input  3  current pipeline stage select
- wb_valid_i  input  1  result offered by execute
- wb_ready_o  output  1  queue can accept this cycle
- wb_rd_i  input  5  destination register index
- wb_data_i  input  32  result value
- wb_itype_i  input  5  instruction type (`RTYPE`/`ITYPE`/`UTYPE` write; anything else does not)
- rs1_i, rs2_i  input  5 each  decode read addresses
- ra_o, rb_o  output  32 each  read data for rs1_i / rs2_i
- pending_o  output  32  bit n = 1 while a write to xn is queued
- commit_o  output  1  pulses the cycle after a register write
- retire_cnt_o  output  32  count of committed register writes

## Operation
- Handshake: transfer when wb_valid_i & wb_ready_o at the rising edge. wb_ready_o = !full (no same-cycle full pass-through).
- Filtering at accept: if wb_rd_i == 0 or wb_itype_i is not RTYPE/ITYPE/UTYPE, the transfer completes but nothing is enqueued.
- FIFO: 2 entries {rd, data}; head/tail pointers wrap modulo 2; count 0..2.
- Commit: when count > 0 and stage_i == WB_STAGE, head entry writes regs[rd] <= data, head advances, commit_o <= 1, retire_cnt_o increments (wraps 0xFFFFFFFF -> 0). Otherwise commit_o <= 0.
- Simultaneous accept and commit: both happen; count unchanged; allowed only when not full (ready low when full).
- Two queued entries to the same rd commit in order; the younger value wins.
- Read ports: combinational; index 0 returns 0; otherwise architected regs[idx] (see Configuration).
- pending_o: OR of one-hot rd over valid FIFO entries; bit 0 always 0.
- States (count): EMPTY(0) -> ONE on accept; ONE -> TWO on accept w/o commit, -> EMPTY on commit w/o accept; TWO -> ONE on commit.

## Timing
- Reset (reset = 0, asynchronous): x1..x31 = 0, FIFO empty, wb_ready_o = 1, pending_o = 0, commit_o = 0, retire_cnt_o = 0, ra_o/rb_o = 0. Reset mid-operation discards queued entries.
- Minimum latency: accepted at edge N, committed at edge N+1 (if stage_i == WB_STAGE in cycle N+1); architected value visible on ra_o/rb_o after edge N+1; commit_o high during cycle N+1..N+2 window (one cycle).
- pending_o updates on the same edges as FIFO contents.

## Configuration
- WB_BYPASS_EN defined: ra_o/rb_o return data of the youngest queued entry whose rd matches (index ≠ 0), else architected value; decode sees a result one edge after acceptance.
- Undefined: read ports return architected value only; consumers must stall on pending_o.

## Test plan
- Reset: hold reset = 0, drive all inputs -> all outputs 0, wb_ready_o = 1; release, rs1_i = 5 -> ra_o = 0.
- Single write: accept rd=5, data=0xDEADBEEF, RTYPE, stage_i = WB_STAGE -> next edge commit; ra_o(rs1=5) = 0xDEADBEEF, commit_o 1 for one cycle, retire_cnt_o = 1.
- Backpressure: stage_i ≠ WB_STAGE, offer 3 results -> wb_ready_o drops after 2; pending_o bits set; third transfers only after a commit.
- Filtering: rd=0 with data 0x1234 and rd=7 with STYPE -> nothing enqueued, ra_o(0) = 0, x7 unchanged, retire_cnt_o unchanged.
- Same-rd ordering: queue rd=3 data 1 then data 2 -> after both commits x3 = 2; with WB_BYPASS_EN rb_o(rs2=3) = 2 before either commits, without it = 0.
- Async reset mid-flight: two entries queued, pull reset low between edges -> pending_o = 0, wb_ready_o = 1 immediately, no writes occur.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback: writeback side of the integer register file.
// A 2-entry result FIFO fed by execute drains into x1..x31, one entry per WB_STAGE cycle.
// Optional feature macro: WB_BYPASS_EN (read ports forward the youngest queued result).
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   stage_i                             current pipeline stage; commits only in WB_STAGE
//   wb_valid_i/wb_ready_o               result handshake from execute
//   wb_rd_i, wb_data_i, wb_itype_i      destination, value and instruction type of the result
//   rs1_i/ra_o, rs2_i/rb_o              combinational decode read ports
//   pending_o                           one-hot OR of destinations still queued
//   commit_o, retire_cnt_o              commit pulse and committed-write counter
module regfile_writeback #(
    parameter logic [2:0] WB_STAGE   = 3'd4,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  stage_i,
    input  logic        wb_valid_i,
    output logic        wb_ready_o,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic [4:0]  wb_itype_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] ra_o,
    output logic [31:0] rb_o,
    output logic [31:0] pending_o,
    output logic        commit_o,
    output logic [31:0] retire_cnt_o
);
    // Instruction type codes shared with decode.
    localparam logic [4:0] RTYPE = 5'd1;
    localparam logic [4:0] ITYPE = 5'd2;
    localparam logic [4:0] UTYPE = 5'd5;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} cnt_e;

    cnt_e        cnt_q, cnt_d;
    logic        head_q, head_d, tail_q, tail_d;
    logic [4:0]  fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]  fifo_rd_d   [FIFO_DEPTH];
    logic [31:0] fifo_data_q [FIFO_DEPTH];
    logic [31:0] fifo_data_d [FIFO_DEPTH];
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        commit_q, commit_d;
    logic [31:0] retire_q, retire_d;
    logic        accept, enq, deq;
    logic [1:0]  ent_vld;

    // With one entry queued it sits at head; with two both slots are live.
    assign ent_vld[0] = (cnt_q == TWO) || (cnt_q == ONE && !head_q);
    assign ent_vld[1] = (cnt_q == TWO) || (cnt_q == ONE && head_q);

    function automatic logic [31:0] rd_port(input logic [4:0] idx);
        logic [31:0] v;
        v = (idx == 5'd0) ? 32'd0 : regs_q[idx];
`ifdef WB_BYPASS_EN
        // Older entry first so the younger one (just before tail) overrides it.
        if (idx != 5'd0 && ent_vld[head_q] && fifo_rd_q[head_q] == idx)
            v = fifo_data_q[head_q];
        if (idx != 5'd0 && ent_vld[~tail_q] && fifo_rd_q[~tail_q] == idx)
            v = fifo_data_q[~tail_q];
`endif
        return v;
    endfunction

    always_comb begin
        wb_ready_o = (cnt_q != TWO);
        accept = wb_valid_i && wb_ready_o;
        // Non-writing results and x0 targets complete the handshake but are dropped.
        enq = accept && (wb_rd_i != 5'd0) &&
              (wb_itype_i == RTYPE || wb_itype_i == ITYPE || wb_itype_i == UTYPE);
        deq = (cnt_q != EMPTY) && (stage_i == WB_STAGE);
        fifo_rd_d = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        if (enq) begin
            fifo_rd_d[tail_q] = wb_rd_i;
            fifo_data_d[tail_q] = wb_data_i;
        end
        tail_d = tail_q ^ enq;
        head_d = head_q ^ deq;
        cnt_d = cnt_q;
        case ({enq, deq})
            2'b10:   cnt_d = (cnt_q == EMPTY) ? ONE : TWO;
            2'b01:   cnt_d = (cnt_q == TWO) ? ONE : EMPTY;
            default: cnt_d = cnt_q;
        endcase
        regs_d = regs_q;
        if (deq)
            regs_d[fifo_rd_q[head_q]] = fifo_data_q[head_q];
        commit_d = deq;
        retire_d = retire_q + 32'(deq);
        pending_o = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (ent_vld[i])
                pending_o[fifo_rd_q[i]] = 1'b1;
        pending_o[0] = 1'b0;
        commit_o = commit_q;
        retire_cnt_o = retire_q;
        ra_o = rd_port(rs1_i);
        rb_o = rd_port(rs2_i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= EMPTY;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
            commit_q <= 1'b0;
            retire_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            fifo_rd_q <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            regs_q <= regs_d;
            commit_q <= commit_d;
            retire_q <= retire_d;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed vector table plus hand sequences for regfile_writeback.
module tb_regfile_writeback;
    localparam logic [4:0] R = 5'd1, I = 5'd2, S = 5'd3, U = 5'd5;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  stage_i;
    logic        wb_valid_i;
    logic        wb_ready_o;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic [4:0]  wb_itype_i;
    logic [4:0]  rs1_i, rs2_i;
    logic [31:0] ra_o, rb_o, pending_o, retire_cnt_o;
    logic        commit_o;

    int checks = 0;
    int errors = 0;

    regfile_writeback dut (
        .clk(clk), .reset(reset), .stage_i(stage_i),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_itype_i(wb_itype_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .ra_o(ra_o), .rb_o(rb_o),
        .pending_o(pending_o), .commit_o(commit_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  it;
        logic [2:0]  st;
        logic [4:0]  r1, r2;
        logic        rdy;
        logic [31:0] ra, rb, pend;
        logic        cm;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic [4:0] it, input logic [2:0] st,
                         input logic [4:0] r1, input logic [4:0] r2);
        wb_valid_i = v; wb_rd_i = rd; wb_data_i = d; wb_itype_i = it;
        stage_i = st; rs1_i = r1; rs2_i = r2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            v  rd     data          it st r1     r2     rdy ra            rb            pending                   cm ret
        tbl[0]  = '{1, 5'd5,  32'hDEADBEEF, R, 0, 5'd0,  5'd0,  1, 32'h0,        32'h0,        32'h0000_0020,            0, 0};
        tbl[1]  = '{0, 5'd0,  32'h0,        R, 4, 5'd5,  5'd0,  1, 32'hDEADBEEF, 32'h0,        32'h0,                    1, 1};
        tbl[2]  = '{0, 5'd0,  32'h0,        R, 0, 5'd5,  5'd0,  1, 32'hDEADBEEF, 32'h0,        32'h0,                    0, 1};
        tbl[3]  = '{1, 5'd0,  32'h1234,     R, 0, 5'd0,  5'd7,  1, 32'h0,        32'h0,        32'h0,                    0, 1};
        tbl[4]  = '{1, 5'd7,  32'h5555,     S, 0, 5'd0,  5'd7,  1, 32'h0,        32'h0,        32'h0,                    0, 1};
        tbl[5]  = '{0, 5'd0,  32'h0,        R, 4, 5'd5,  5'd7,  1, 32'hDEADBEEF, 32'h0,        32'h0,                    0, 1};
        tbl[6]  = '{1, 5'd10, 32'hA,        I, 0, 5'd5,  5'd0,  1, 32'hDEADBEEF, 32'h0,        32'h0000_0400,            0, 1};
        tbl[7]  = '{1, 5'd11, 32'hB,        U, 0, 5'd5,  5'd0,  0, 32'hDEADBEEF, 32'h0,        32'h0000_0C00,            0, 1};
        tbl[8]  = '{1, 5'd12, 32'hC,        R, 0, 5'd0,  5'd0,  0, 32'h0,        32'h0,        32'h0000_0C00,            0, 1};
        tbl[9]  = '{1, 5'd12, 32'hC,        R, 4, 5'd10, 5'd0,  1, 32'hA,        32'h0,        32'h0000_0800,            1, 2};
        tbl[10] = '{1, 5'd12, 32'hC,        R, 4, 5'd11, 5'd10, 1, 32'hB,        32'hA,        32'h0000_1000,            1, 3};
        tbl[11] = '{0, 5'd0,  32'h0,        R, 4, 5'd12, 5'd0,  1, 32'hC,        32'h0,        32'h0,                    1, 4};
        tbl[12] = '{0, 5'd0,  32'h0,        R, 4, 5'd12, 5'd0,  1, 32'hC,        32'h0,        32'h0,                    0, 4};
        tbl[13] = '{1, 5'd9,  32'h99,       R, 4, 5'd0,  5'd0,  1, 32'h0,        32'h0,        32'h0000_0200,            0, 4};
        tbl[14] = '{1, 5'd9,  32'h100,      R, 4, 5'd12, 5'd0,  1, 32'hC,        32'h0,        32'h0000_0200,            1, 5};
        tbl[15] = '{0, 5'd0,  32'h0,        R, 4, 5'd9,  5'd0,  1, 32'h100,      32'h0,        32'h0,                    1, 6};

        // Reset held with live inputs: nothing may be accepted or committed.
        reset = 1'b0;
        drive(1, 5'd5, 32'hFFFF_FFFF, R, 4, 5'd5, 5'd5);
        tick; tick;
        chk("rst ready", 32'(wb_ready_o), 32'd1);
        chk("rst pending", pending_o, 32'd0);
        chk("rst commit", 32'(commit_o), 32'd0);
        chk("rst retire", retire_cnt_o, 32'd0);
        chk("rst ra", ra_o, 32'd0);
        chk("rst rb", rb_o, 32'd0);
        drive(0, 5'd0, 32'd0, R, 0, 5'd5, 5'd0);
        reset = 1'b1;
        tick;
        chk("post-rst ra x5", ra_o, 32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].rd, tbl[i].data, tbl[i].it, tbl[i].st, tbl[i].r1, tbl[i].r2);
            tick;
            chk($sformatf("v%0d ready", i), 32'(wb_ready_o), 32'(tbl[i].rdy));
            chk($sformatf("v%0d ra", i), ra_o, tbl[i].ra);
            chk($sformatf("v%0d rb", i), rb_o, tbl[i].rb);
            chk($sformatf("v%0d pending", i), pending_o, tbl[i].pend);
            chk($sformatf("v%0d commit", i), 32'(commit_o), 32'(tbl[i].cm));
            chk($sformatf("v%0d retire", i), retire_cnt_o, tbl[i].ret);
        end

        // Same-rd ordering: younger value must win.
        drive(1, 5'd3, 32'd1, R, 0, 5'd0, 5'd3);
        tick;
        drive(1, 5'd3, 32'd2, I, 0, 5'd0, 5'd3);
        tick;
        chk("ord pending", pending_o, 32'h0000_0008);
        chk("ord ready", 32'(wb_ready_o), 32'd0);
        chk("ord rb queued", rb_o, BYP ? 32'd2 : 32'd0);
        drive(0, 5'd0, 32'd0, R, 4, 5'd0, 5'd3);
        tick;
        chk("ord rb one", rb_o, BYP ? 32'd2 : 32'd1);
        chk("ord commit1", 32'(commit_o), 32'd1);
        tick;
        chk("ord rb two", rb_o, 32'd2);
        chk("ord retire", retire_cnt_o, 32'd8);
        chk("ord pending0", pending_o, 32'd0);

        // Asynchronous reset between edges with two entries queued.
        drive(1, 5'd20, 32'd20, R, 0, 5'd3, 5'd20);
        tick;
        drive(1, 5'd21, 32'd21, R, 0, 5'd3, 5'd20);
        tick;
        chk("ar pending before", pending_o, 32'h0030_0000);
        drive(0, 5'd0, 32'd0, R, 4, 5'd3, 5'd20);
        #2;
        reset = 1'b0;
        #1;
        chk("ar pending", pending_o, 32'd0);
        chk("ar ready", 32'(wb_ready_o), 32'd1);
        chk("ar retire", retire_cnt_o, 32'd0);
        chk("ar ra x3", ra_o, 32'd0);
        tick;
        chk("ar held rb x20", rb_o, 32'd0);
        chk("ar held commit", 32'(commit_o), 32'd0);
        reset = 1'b1;
        tick;
        chk("ar after rb x20", rb_o, 32'd0);
        chk("ar after retire", retire_cnt_o, 32'd0);
        chk("ar after commit", 32'(commit_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
